// File: rtl/buffer_gate_unit.sv
// Non-inverting single-bit buffer with a clocked edge/stuck monitor on the input.
// The c path is purely combinational; the monitor is observability only.
module buffer_gate_unit #(
    parameter int CNT_WIDTH   = 16,
    parameter int STUCK_LIMIT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a,
    output logic                 c,
    input  logic                 clr,
    output logic                 a_q,
    output logic [CNT_WIDTH-1:0] rise_cnt,
    output logic [CNT_WIDTH-1:0] fall_cnt,
    output logic                 stuck
);

    localparam int STAB_W = (STUCK_LIMIT < 2) ? 1 : $clog2(STUCK_LIMIT + 1);
    localparam logic [STAB_W-1:0]    STAB_MAX = STAB_W'(STUCK_LIMIT);
    localparam logic [STAB_W-1:0]    STAB_ONE = STAB_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sample_q, sample_d;
    logic [CNT_WIDTH-1:0] rise_q, rise_d;
    logic [CNT_WIDTH-1:0] fall_q, fall_d;
    logic [STAB_W-1:0]    stab_q, stab_d;
    logic                 stuck_q, stuck_d;
    logic                 chg;

    assign c = a;

    always_comb begin
        chg      = (a != sample_q);
        sample_d = a;
        rise_d   = rise_q;
        fall_d   = fall_q;
        stab_d   = stab_q;
        if (clr) begin
            rise_d = '0;
            fall_d = '0;
            stab_d = '0;
        end else begin
            if (chg && a && (rise_q != '1))
                rise_d = rise_q + CNT_ONE;
            if (chg && !a && (fall_q != '1))
                fall_d = fall_q + CNT_ONE;
            if (chg)
                stab_d = '0;
            else if (stab_q != STAB_MAX)
                stab_d = stab_q + STAB_ONE;
        end
        // Flag follows the counter value it will hold after this edge.
        stuck_d = !clr && (stab_d == STAB_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= 1'b0;
            rise_q   <= '0;
            fall_q   <= '0;
            stab_q   <= '0;
            stuck_q  <= 1'b0;
        end else begin
            sample_q <= sample_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            stab_q   <= stab_d;
            stuck_q  <= stuck_d;
        end
    end

    assign a_q      = sample_q;
    assign rise_cnt = rise_q;
    assign fall_cnt = fall_q;
    assign stuck    = stuck_q;

endmodule

// File: tb/tb_buffer_gate_unit.sv
// Directed + random bench for buffer_gate_unit: a 16-bit/limit-4 instance and a
// 2-bit/limit-3 instance share stimulus; a behavioural model feeds a scoreboard queue.
module tb_buffer_gate_unit;

    typedef struct packed {
        logic        aq;
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] stab;
        logic        stuck;
    } ms_t;

    typedef struct packed {
        ms_t m0;
        ms_t m1;
    } exp_t;

    logic clk, clk_en, rst, clr, a;
    logic c0, aq0, stuck0, c1, aq1, stuck1;
    logic [15:0] rise0, fall0;
    logic [1:0]  rise1, fall1;

    int n_pass  = 0;
    int n_total = 0;
    exp_t sb[$];
    ms_t s0 = '0;
    ms_t s1 = '0;

    buffer_gate_unit #(.CNT_WIDTH(16), .STUCK_LIMIT(4)) u_main (
        .clk(clk), .rst(rst), .a(a), .c(c0), .clr(clr), .a_q(aq0),
        .rise_cnt(rise0), .fall_cnt(fall0), .stuck(stuck0)
    );

    buffer_gate_unit #(.CNT_WIDTH(2), .STUCK_LIMIT(3)) u_sat (
        .clk(clk), .rst(rst), .a(a), .c(c1), .clr(clr), .a_q(aq1),
        .rise_cnt(rise1), .fall_cnt(fall1), .stuck(stuck1)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic ms_t nxt(ms_t s, int maxv, int lim, logic av, logic rv, logic cv);
        ms_t n = s;
        logic ch = (av != s.aq);
        if (rv) begin
            n = '0;
        end else begin
            n.aq = av;
            if (cv) begin
                n.rise = 0; n.fall = 0; n.stab = 0; n.stuck = 1'b0;
            end else begin
                if (ch && av && s.rise < maxv) n.rise = s.rise + 1;
                if (ch && !av && s.fall < maxv) n.fall = s.fall + 1;
                if (ch) n.stab = 0;
                else if (s.stab < lim) n.stab = s.stab + 1;
                n.stuck = (n.stab == lim);
            end
        end
        return n;
    endfunction

    task automatic step(input logic av, input logic rv, input logic cv);
        exp_t e;
        a = av; rst = rv; clr = cv;
        #1;
        chk("c_comb_main", {31'b0, c0}, {31'b0, av});
        chk("c_comb_sat", {31'b0, c1}, {31'b0, av});
        s0 = nxt(s0, 65535, 4, av, rv, cv);
        s1 = nxt(s1, 3, 3, av, rv, cv);
        e.m0 = s0;
        e.m1 = s1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_nonempty", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("a_q_main",   {31'b0, aq0},    {31'b0, e.m0.aq});
            chk("rise_main",  {16'b0, rise0},  e.m0.rise);
            chk("fall_main",  {16'b0, fall0},  e.m0.fall);
            chk("stuck_main", {31'b0, stuck0}, {31'b0, e.m0.stuck});
            chk("a_q_sat",    {31'b0, aq1},    {31'b0, e.m1.aq});
            chk("rise_sat",   {30'b0, rise1},  e.m1.rise);
            chk("fall_sat",   {30'b0, fall1},  e.m1.fall);
            chk("stuck_sat",  {31'b0, stuck1}, {31'b0, e.m1.stuck});
        end
    endtask

    initial begin
        clk_en = 1'b0;
        rst = 1'b0; clr = 1'b0;

        // clockless pass-through
        a = 1'b0; #5; chk("noclk_c0", {31'b0, c0}, 32'd0);
        a = 1'b1; #5; chk("noclk_c1", {31'b0, c0}, 32'd1);
        a = 1'bx; #5; chk("noclk_cx", {31'b0, c0}, {31'b0, 1'bx});
        a = 1'b0;

        clk_en = 1'b1;
        @(posedge clk); #1;

        step(0, 1, 0); step(0, 1, 0);
        chk("rst_rise", {16'b0, rise0}, 32'd0);
        chk("rst_stuck", {31'b0, stuck0}, 32'd0);

        // stuck after exactly 4 edges from reset release
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("stuck_not_yet", {31'b0, stuck0}, 32'd0);
        chk("stuck_sat_lim3", {31'b0, stuck1}, 32'd1);
        step(0, 0, 0);
        chk("stuck_at_4", {31'b0, stuck0}, 32'd1);

        // toggling clears stuck and counts edges
        step(1, 0, 0);
        chk("stuck_clear", {31'b0, stuck0}, 32'd0);
        step(0, 0, 0); step(1, 0, 0);
        chk("toggle_rise", {16'b0, rise0}, 32'd2);
        chk("toggle_fall", {16'b0, fall0}, 32'd1);
        chk("toggle_aq", {31'b0, aq0}, 32'd1);

        // saturation of the 2-bit counters
        step(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0); step(0, 0, 0);
        end
        chk("sat_rise", {30'b0, rise1}, 32'd3);
        chk("main_rise5", {16'b0, rise0}, 32'd5);

        // clr beats a coincident rising edge
        step(0, 1, 0);
        step(1, 0, 0); step(0, 0, 0);
        chk("pre_clr_rise", {16'b0, rise0}, 32'd1);
        step(1, 0, 1);
        chk("clr_rise", {16'b0, rise0}, 32'd0);
        chk("clr_fall", {16'b0, fall0}, 32'd0);
        chk("clr_aq", {31'b0, aq0}, 32'd1);
        step(1, 0, 0); step(0, 0, 0);

        // rst and clr together
        step(1, 1, 1);
        chk("rst_clr_aq", {31'b0, aq0}, 32'd0);
        chk("rst_clr_fall", {16'b0, fall0}, 32'd0);

        // held reset while a toggles
        for (int i = 0; i < 6; i++) step(logic'(i[0]), 1, 0);
        chk("rst_hold_rise", {16'b0, rise0}, 32'd0);

        // random traffic
        step(0, 0, 0);
        for (int i = 0; i < 60; i++)
            step(logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 9) == 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
